// File: rtl/hwpe_ctrl_job_dispatcher.sv
// hwpe_ctrl_job_dispatcher: queues job descriptors and runs acquire/configure/trigger/wait on an HWPE control port.
module hwpe_ctrl_job_dispatcher #(
    parameter int          N_REQ         = 4,
    parameter int          N_CFG_WORDS   = 4,
    parameter int          FIFO_DEPTH    = 4,
    parameter int          ID_WIDTH      = 16,
    parameter logic [31:0] TRIGGER_ADDR  = 32'h00,
    parameter logic [31:0] ACQUIRE_ADDR  = 32'h04,
    parameter logic [31:0] CFG_BASE_ADDR = 32'h40,
    parameter int          RETRY_WAIT    = 8,
    localparam int         SW            = N_REQ > 1 ? $clog2(N_REQ) : 1,
    localparam int         PW            = $clog2(FIFO_DEPTH)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        job_valid_i,
    output logic                        job_ready_o,
    input  logic [SW-1:0]               job_src_i,
    input  logic [N_CFG_WORDS*32-1:0]   job_data_i,
    output logic                        cfg_req_o,
    input  logic                        cfg_gnt_i,
    output logic [31:0]                 cfg_add_o,
    output logic                        cfg_we_n_o,
    output logic [3:0]                  cfg_be_o,
    output logic [31:0]                 cfg_data_o,
    output logic [ID_WIDTH-1:0]         cfg_id_o,
    input  logic                        cfg_r_valid_i,
    input  logic [31:0]                 cfg_r_data_i,
    input  logic                        done_i,
    output logic                        job_done_o,
    output logic [SW-1:0]               job_done_src_o,
    output logic                        busy_o,
    output logic [PW:0]                 pending_o
);
    localparam int KW = N_CFG_WORDS > 1 ? $clog2(N_CFG_WORDS) : 1;
    localparam int BW = RETRY_WAIT > 1 ? $clog2(RETRY_WAIT) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N_CFG_WORDS - 1);
    localparam logic [BW-1:0] B_LAST = BW'(RETRY_WAIT - 1);

    typedef enum logic [3:0] {
        IDLE, ACQ_REQ, ACQ_WAIT, BACKOFF, CFG_REQ, CFG_WAIT, TRIG_REQ, TRIG_WAIT, RUN
    } state_t;

    state_t state, state_n;

    logic [SW+N_CFG_WORDS*32-1:0]      fifo [FIFO_DEPTH];
    logic [PW:0]                       wr_ptr, rd_ptr, count;
    logic                              full, empty, push, pop;
    logic [SW-1:0]                     job_src;
    logic [N_CFG_WORDS-1:0][31:0]      job_data;
    logic [KW-1:0]                     k;
    logic [BW-1:0]                     bcnt;
    logic                              stale, rvalid, waiting, finish;

    assign count   = wr_ptr - rd_ptr;
    assign full    = count == (PW+1)'(FIFO_DEPTH);
    assign empty   = count == '0;
    assign push    = job_valid_i && !full && !flush_i;
    assign pop     = state == IDLE && !empty && !flush_i;
    assign waiting = state inside {ACQ_WAIT, CFG_WAIT, TRIG_WAIT};
    assign rvalid  = cfg_r_valid_i && !stale;
    assign finish  = state == RUN && done_i && !flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo[wr_ptr[PW-1:0]] <= {job_src_i, job_data_i};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (!empty) state_n = ACQ_REQ;
            ACQ_REQ:   if (cfg_gnt_i) state_n = ACQ_WAIT;
            ACQ_WAIT:  if (rvalid) state_n = $signed(cfg_r_data_i) < 0 ? BACKOFF : CFG_REQ;
            BACKOFF:   if (bcnt == B_LAST) state_n = ACQ_REQ;
            CFG_REQ:   if (cfg_gnt_i) state_n = CFG_WAIT;
            CFG_WAIT:  if (rvalid) state_n = k == K_LAST ? TRIG_REQ : CFG_REQ;
            TRIG_REQ:  if (cfg_gnt_i) state_n = TRIG_WAIT;
            TRIG_WAIT: if (rvalid) state_n = RUN;
            RUN:       if (done_i) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
        if (flush_i) state_n = IDLE;
    end

    // A flush with a granted but unanswered transaction marks its response as stale so it is dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            job_src        <= '0;
            job_data       <= '0;
            k              <= '0;
            bcnt           <= '0;
            stale          <= 1'b0;
            job_done_o     <= 1'b0;
            job_done_src_o <= '0;
        end else begin
            if (pop) {job_src, job_data} <= fifo[rd_ptr[PW-1:0]];
            k <= state == CFG_WAIT && rvalid && k != K_LAST ? k + 1'b1 :
                 state inside {CFG_REQ, CFG_WAIT} ? k : '0;
            bcnt <= state == BACKOFF && bcnt != B_LAST ? bcnt + 1'b1 : '0;
            stale <= flush_i ? (waiting && !cfg_r_valid_i) || (cfg_req_o && cfg_gnt_i) :
                     stale && !cfg_r_valid_i;
            job_done_o     <= finish;
            job_done_src_o <= finish ? job_src : '0;
        end
    end

    always_comb begin
        cfg_req_o   = state inside {ACQ_REQ, CFG_REQ, TRIG_REQ};
        cfg_we_n_o  = state == ACQ_REQ;
        cfg_add_o   = state == ACQ_REQ  ? ACQUIRE_ADDR :
                      state == CFG_REQ  ? CFG_BASE_ADDR + 32'({k, 2'b00}) :
                      state == TRIG_REQ ? TRIGGER_ADDR : '0;
        cfg_data_o  = state == CFG_REQ ? job_data[k] : '0;
        cfg_be_o    = cfg_req_o ? 4'hF : 4'h0;
        cfg_id_o    = cfg_req_o ? ID_WIDTH'(1) << job_src : '0;
        busy_o      = state != IDLE;
        job_ready_o = !full;
        pending_o   = count;
    end
endmodule

// File: tb/tb_hwpe_ctrl_job_dispatcher.sv
// tb_hwpe_ctrl_job_dispatcher: directed jobs against a slave-port model, checked through a transaction scoreboard.
module tb_hwpe_ctrl_job_dispatcher;
    localparam int RW = 8;

    logic         clk = 1'b0;
    logic         rst, flush, job_valid, job_ready;
    logic [1:0]   job_src, job_done_src;
    logic [127:0] job_data;
    logic         cfg_req, cfg_gnt, cfg_we_n, cfg_r_valid;
    logic [31:0]  cfg_add, cfg_data, cfg_r_data;
    logic [3:0]   cfg_be;
    logic [15:0]  cfg_id;
    logic         done, slave_done, man_done, job_done, busy;
    logic [2:0]   pending;

    typedef struct packed {
        logic [31:0] add;
        logic        we_n;
        logic [31:0] data;
        logic [15:0] id;
    } txn_t;

    txn_t        exp_txn[$];
    logic [1:0]  exp_done[$];
    logic [31:0] acq_vals[$];
    int          passed = 0, total = 0;

    bit          gnt_block = 0, auto_done = 1;
    int          stall_left = 0;
    logic [31:0] stall_addr = 32'hFFFF_FFFF;

    always #5 clk = ~clk;
    assign done = slave_done | man_done;

    hwpe_ctrl_job_dispatcher dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .job_valid_i(job_valid), .job_ready_o(job_ready), .job_src_i(job_src), .job_data_i(job_data),
        .cfg_req_o(cfg_req), .cfg_gnt_i(cfg_gnt), .cfg_add_o(cfg_add), .cfg_we_n_o(cfg_we_n),
        .cfg_be_o(cfg_be), .cfg_data_o(cfg_data), .cfg_id_o(cfg_id),
        .cfg_r_valid_i(cfg_r_valid), .cfg_r_data_i(cfg_r_data), .done_i(done),
        .job_done_o(job_done), .job_done_src_o(job_done_src), .busy_o(busy), .pending_o(pending)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        total++;
        $display("FAIL %s", name);
    endtask

    // Slave model: grants requests, answers one cycle after the grant, raises done after a trigger.
    initial begin
        bit          gnt_now, trig_now;
        logic [31:0] resp;
        int          done_cnt;
        gnt_now = 0; trig_now = 0; resp = '0; done_cnt = 0;
        cfg_gnt = 0; cfg_r_valid = 0; cfg_r_data = '0; slave_done = 0;
        forever begin
            @(negedge clk);
            cfg_r_valid = 0;
            slave_done = 0;
            if (rst) begin
                cfg_gnt = 0; gnt_now = 0; done_cnt = 0;
                continue;
            end
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) slave_done = 1;
            end
            if (gnt_now) begin
                cfg_r_valid = 1;
                cfg_r_data = resp;
                if (trig_now && auto_done) done_cnt = 10;
            end
            cfg_gnt = 0;
            gnt_now = 0;
            if (cfg_req && !gnt_block) begin
                if (cfg_add == stall_addr && stall_left > 0) stall_left--;
                else begin
                    cfg_gnt = 1;
                    gnt_now = 1;
                    trig_now = !cfg_we_n && cfg_add == 32'h0;
                    resp = cfg_we_n && acq_vals.size() > 0 ? acq_vals.pop_front() : 32'h0;
                end
            end
        end
    end

    // Monitor: every requesting cycle must match the scoreboard head; grants retire it.
    initial begin
        int   cyc, last_fail;
        bit   acq_pending, prev_req;
        txn_t t;
        cyc = 0; last_fail = -1; acq_pending = 0; prev_req = 0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (rst) begin
                prev_req = 0; last_fail = -1; acq_pending = 0;
                continue;
            end
            if (cfg_r_valid) begin
                if (acq_pending && cfg_r_data[31]) last_fail = cyc;
                acq_pending = 0;
            end
            if (cfg_req && cfg_we_n && !prev_req && last_fail >= 0) begin
                check("retry_gap", cyc - last_fail, RW + 1);
                last_fail = -1;
            end
            if (cfg_req) begin
                if (exp_txn.size() == 0) fail("unexpected_txn");
                else begin
                    t = exp_txn[0];
                    check("txn_add", cfg_add, t.add);
                    check("txn_we_n", cfg_we_n, t.we_n);
                    check("txn_data", cfg_data, t.data);
                    check("txn_id", cfg_id, t.id);
                    check("txn_be", cfg_be, 4'hF);
                    if (cfg_gnt) begin
                        void'(exp_txn.pop_front());
                        if (cfg_we_n) acq_pending = 1;
                    end
                end
            end
            prev_req = cfg_req;
            if (job_done) begin
                if (exp_done.size() == 0) fail("unexpected_done");
                else check("done_src", job_done_src, exp_done.pop_front());
            end
        end
    end

    // mode: 0 = no expectations, 1 = transactions only, 2 = transactions and completion.
    task automatic push_job(input logic [1:0] src, input logic [127:0] data, input int nfail, input int mode);
        txn_t t;
        job_valid = 1; job_src = src; job_data = data;
        for (int w = 0; w < 400 && !job_ready; w++) @(negedge clk);
        if (!job_ready) fail("push_timeout");
        else if (mode > 0) begin
            t.id = 16'(1) << src;
            for (int i = 0; i <= nfail; i++) begin
                t.add = 32'h04; t.we_n = 1; t.data = '0;
                exp_txn.push_back(t);
            end
            for (int i = 0; i < 4; i++) begin
                t.add = 32'h40 + 32'(4 * i); t.we_n = 0; t.data = data[32*i +: 32];
                exp_txn.push_back(t);
            end
            t.add = 32'h00; t.we_n = 0; t.data = '0;
            exp_txn.push_back(t);
            if (mode == 2) exp_done.push_back(src);
        end
        @(negedge clk);
        job_valid = 0;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 2000; i++) begin
            if (exp_txn.size() == 0 && exp_done.size() == 0 && !busy && pending == 0) break;
            @(negedge clk);
        end
        if (i == 2000) fail("drain_timeout");
        @(negedge clk);
    endtask

    initial begin
        int i;
        rst = 1; flush = 0; job_valid = 0; job_src = '0; job_data = '0; man_done = 0;
        repeat (3) @(negedge clk);
        check("rst_ready", job_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_pending", pending, 0);
        check("rst_req", cfg_req, 0);
        check("rst_add", cfg_add, 0);
        check("rst_done", job_done, 0);
        check("rst_done_src", job_done_src, 0);
        check("rst_id", cfg_id, 0);
        rst = 0;
        @(negedge clk);

        // 1: single job, acquire succeeds first time
        push_job(2'd2, {32'd4, 32'd3, 32'd2, 32'd1}, 0, 2);
        drain();

        // 2: two failed acquires then success
        acq_vals.push_back(32'hFFFF_FFFF);
        acq_vals.push_back(32'hFFFF_FFFF);
        acq_vals.push_back(32'h0);
        push_job(2'd1, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 2, 2);
        drain();

        // 3: stalled slave fills the queue; sixth push waits for a pop
        gnt_block = 1;
        for (int j = 0; j < 5; j++)
            push_job(2'(j), {32'(j * 16 + 3), 32'(j * 16 + 2), 32'(j * 16 + 1), 32'(j * 16)}, 0, 2);
        check("full_pending", pending, 4);
        check("full_ready", job_ready, 0);
        fork
            push_job(2'd3, {32'h53, 32'h52, 32'h51, 32'h50}, 0, 2);
            begin
                repeat (4) @(negedge clk);
                check("full_held", job_ready, 0);
                gnt_block = 0;
            end
        join
        drain();

        // 4: grant withheld for 3 cycles on the third config word
        stall_addr = 32'h48; stall_left = 3;
        push_job(2'd0, {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000}, 0, 2);
        drain();
        check("stall_used", stall_left, 0);
        stall_addr = 32'hFFFF_FFFF;

        // 5: flush in RUN with a queued job and a simultaneous push
        auto_done = 0;
        push_job(2'd1, {32'h11, 32'h12, 32'h13, 32'h14}, 0, 1);
        for (i = 0; i < 200 && exp_txn.size() != 0; i++) @(negedge clk);
        if (i == 200) fail("run_timeout");
        repeat (3) @(negedge clk);
        push_job(2'd3, {32'h21, 32'h22, 32'h23, 32'h24}, 0, 0);
        check("flush_pre_pending", pending, 1);
        flush = 1; job_valid = 1; job_src = 2'd2;
        @(negedge clk);
        flush = 0; job_valid = 0;
        check("flush_busy", busy, 0);
        check("flush_pending", pending, 0);
        check("flush_req", cfg_req, 0);
        man_done = 1;
        @(negedge clk);
        man_done = 0;
        @(negedge clk);
        check("flush_no_done", job_done, 0);
        check("flush_idle", busy, 0);
        auto_done = 1;
        push_job(2'd3, {32'h31, 32'h32, 32'h33, 32'h34}, 0, 2);
        drain();

        // 6: asynchronous reset during configuration
        push_job(2'd2, {32'h41, 32'h42, 32'h43, 32'h44}, 0, 2);
        for (i = 0; i < 200 && !(cfg_req && cfg_add == 32'h48); i++) @(negedge clk);
        if (i == 200) fail("cfg_timeout");
        #2 rst = 1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_req", cfg_req, 0);
        check("arst_add", cfg_add, 0);
        check("arst_ready", job_ready, 1);
        check("arst_pending", pending, 0);
        exp_txn.delete();
        exp_done.delete();
        @(negedge clk);
        rst = 0;
        man_done = 1;
        @(negedge clk);
        man_done = 0;
        @(negedge clk);
        check("arst_no_done", job_done, 0);
        check("arst_idle", busy, 0);
        push_job(2'd0, {32'h51, 32'h52, 32'h53, 32'h54}, 0, 2);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
